// File: rtl/can_frame_rx_if.sv
// Bus-sampler / frame-readout bundle of the CAN receive engine.
// The receiver sits on the slave side; the bit source and readout logic sit on the master side.
interface can_frame_rx_if #(
  parameter int MAX_BYTES = 8
);
  logic                   bit_en;
  logic                   rx_bit;
  logic                   frame_valid;
  logic [28:0]            frame_id;
  logic                   frame_ide;
  logic                   frame_rtr;
  logic [3:0]             frame_dlc;
  logic [8*MAX_BYTES-1:0] frame_data;
  logic                   err_stuff;
  logic                   err_crc;
  logic                   err_form;
  logic                   busy;

  modport master (
    output bit_en, rx_bit,
    input  frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data,
    input  err_stuff, err_crc, err_form, busy
  );

  modport slave (
    input  bit_en, rx_bit,
    output frame_valid, frame_id, frame_ide, frame_rtr, frame_dlc, frame_data,
    output err_stuff, err_crc, err_form, busy
  );
endinterface

// File: rtl/can_frame_rx.sv
// CAN 2.0A/2.0B receive engine: bit destuffing, CRC-15 check and field parsing
// in one FSM. Everything advances on the bit_en strobe; outputs are registered.
module can_frame_rx #(
  parameter int          CONSEC    = 5,
  parameter int          MAX_BYTES = 8,
  parameter bit          EXT_EN    = 1'b1,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input logic           clk_i,
  input logic           rst_ni,
  can_frame_rx_if.slave bus
);
  localparam int DW = 8 * MAX_BYTES;
  localparam int RW = $clog2(CONSEC + 1);

  typedef enum logic [3:0] {
    S_WAIT_IDLE, S_IDLE, S_BASE_ID, S_RTR_SRR, S_IDE, S_EXT_ID, S_RTR, S_R1,
    S_R0, S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   run_q, run_d;        // identical-bit run length, stuff bits included
  logic            last_q, last_d;      // value of the previous bus bit in the stuffed region
  logic [3:0]      idle_q, idle_d;      // consecutive recessive bits while waiting for idle
  logic [6:0]      cnt_q, cnt_d;        // bit index within the current field
  logic [14:0]     crc_q, crc_d;        // running CRC over SOF..last data bit
  logic [14:0]     crc_rx_q, crc_rx_d;  // CRC field as received
  logic [28:0]     id_q, id_d;
  logic            ide_q, ide_d, rtr_q, rtr_d;
  logic [3:0]      dlc_q, dlc_d, nbytes_q, nbytes_d;
  logic [7:0]      byte_q, byte_d;
  logic [DW-1:0]   data_q, data_d;

  logic            valid_q, valid_d, estf_q, estf_d, ecrc_q, ecrc_d, efrm_q, efrm_d;
  logic            busy_q, busy_d;
  logic [28:0]     o_id_q, o_id_d;
  logic            o_ide_q, o_ide_d, o_rtr_q, o_rtr_d;
  logic [3:0]      o_dlc_q, o_dlc_d;
  logic [DW-1:0]   o_data_q, o_data_d;

  logic            rx, stuff_zone, is_stuff, abort;
  logic [3:0]      dlc_new, nb;
  logic [7:0]      byte_new;

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic [14:0] s;
    s = {c[13:0], 1'b0};
    if (b ^ c[14]) s = s ^ CRC_POLY;
    return s;
  endfunction

  // Next-state: destuff, CRC, field parsing and error/valid generation
  always_comb begin
    state_d  = state_q;   run_d    = run_q;    last_d  = last_q;  idle_d = idle_q;
    cnt_d    = cnt_q;     crc_d    = crc_q;    crc_rx_d = crc_rx_q;
    id_d     = id_q;      ide_d    = ide_q;    rtr_d   = rtr_q;   dlc_d  = dlc_q;
    nbytes_d = nbytes_q;  byte_d   = byte_q;   data_d  = data_q;
    valid_d  = 1'b0;      estf_d   = 1'b0;     ecrc_d  = 1'b0;    efrm_d = 1'b0;
    busy_d   = busy_q;
    o_id_d   = o_id_q;    o_ide_d  = o_ide_q;  o_rtr_d = o_rtr_q;
    o_dlc_d  = o_dlc_q;   o_data_d = o_data_q;
    abort    = 1'b0;

    rx       = bus.rx_bit;
    dlc_new  = {dlc_q[2:0], rx};
    // Bytes actually on the wire: remote frames carry none, DLC above 8 means 8.
    nb       = rtr_q ? 4'd0 : ((dlc_new > 4'd8) ? 4'd8 : dlc_new);
    byte_new = {byte_q[6:0], rx};
    // A stuff bit may still follow the last CRC bit, so the delimiter slot
    // is destuffed only when a run has just completed.
    stuff_zone = ((state_q >= S_BASE_ID) && (state_q <= S_CRC)) ||
                 ((state_q == S_CRC_DEL) && (run_q == RW'(CONSEC)));
    is_stuff   = stuff_zone && (run_q == RW'(CONSEC));

    if (bus.bit_en) begin
      if (stuff_zone) begin
        if (is_stuff && (rx == last_q)) begin
          estf_d = 1'b1;
          abort  = 1'b1;
        end else if (is_stuff || (rx != last_q)) begin
          last_d = rx;
          run_d  = RW'(1);
        end else begin
          run_d  = run_q + RW'(1);
        end
      end

      if (!is_stuff) begin
        if ((state_q >= S_BASE_ID) && (state_q <= S_DATA)) crc_d = crc_step(crc_q, rx);
        case (state_q)
          S_WAIT_IDLE: begin
            if (!rx)                idle_d  = 4'd0;
            else if (idle_q == 4'd10) state_d = S_IDLE;
            else                    idle_d  = idle_q + 4'd1;
          end
          S_IDLE: begin
            if (!rx) begin
              state_d = S_BASE_ID;  busy_d = 1'b1;  cnt_d = 7'd0;  crc_d = 15'd0;
              id_d    = 29'd0;      ide_d  = 1'b0;  rtr_d = 1'b0;  dlc_d = 4'd0;
              data_d  = '0;         run_d  = RW'(1); last_d = 1'b0;
            end
          end
          S_BASE_ID: begin
            id_d = {id_q[27:0], rx};
            if (cnt_q == 7'd10) begin state_d = S_RTR_SRR; cnt_d = 7'd0; end
            else cnt_d = cnt_q + 7'd1;
          end
          S_RTR_SRR: begin rtr_d = rx; state_d = S_IDE; end
          S_IDE: begin
            ide_d = rx;
            if (rx && !EXT_EN) begin efrm_d = 1'b1; abort = 1'b1; end
            else if (rx)       begin state_d = S_EXT_ID; cnt_d = 7'd0; end
            else               state_d = S_R0;
          end
          S_EXT_ID: begin
            id_d = {id_q[27:0], rx};
            if (cnt_q == 7'd17) state_d = S_RTR;
            else cnt_d = cnt_q + 7'd1;
          end
          S_RTR: begin rtr_d = rx; state_d = S_R1; end
          S_R1:  state_d = S_R0;
          S_R0:  begin state_d = S_DLC; cnt_d = 7'd0; end
          S_DLC: begin
            dlc_d = dlc_new;
            if (cnt_q == 7'd3) begin
              nbytes_d = nb;
              cnt_d    = 7'd0;
              state_d  = (nb == 4'd0) ? S_CRC : S_DATA;
            end else cnt_d = cnt_q + 7'd1;
          end
          S_DATA: begin
            byte_d = byte_new;
            // Bytes past MAX_BYTES are still clocked through the CRC, just not kept.
            if (cnt_q[2:0] == 3'd7)
              for (int b = 0; b < MAX_BYTES; b++)
                if (cnt_q[5:3] == 3'(b)) data_d[8*b +: 8] = byte_new;
            if (cnt_q == ({nbytes_q, 3'b000} - 7'd1)) begin state_d = S_CRC; cnt_d = 7'd0; end
            else cnt_d = cnt_q + 7'd1;
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], rx};
            if (cnt_q == 7'd14) state_d = S_CRC_DEL;
            else cnt_d = cnt_q + 7'd1;
          end
          S_CRC_DEL: begin
            // A bad delimiter outranks a CRC mismatch.
            if (!rx)                        begin efrm_d = 1'b1; abort = 1'b1; end
            else if (crc_rx_q != crc_q)     begin ecrc_d = 1'b1; abort = 1'b1; end
            else                            state_d = S_ACK;
          end
          S_ACK: state_d = S_ACK_DEL;
          S_ACK_DEL: begin
            if (!rx) begin efrm_d = 1'b1; abort = 1'b1; end
            else     begin state_d = S_EOF; cnt_d = 7'd0; end
          end
          S_EOF: begin
            if (cnt_q == 7'd6) begin
              valid_d = 1'b1;   busy_d  = 1'b0;   state_d = S_WAIT_IDLE; idle_d = 4'd0;
              o_id_d  = id_q;   o_ide_d = ide_q;  o_rtr_d = rtr_q;
              o_dlc_d = dlc_q;  o_data_d = data_q;
            end else if (!rx) begin
              efrm_d = 1'b1; abort = 1'b1;
            end else cnt_d = cnt_q + 7'd1;
          end
          default: state_d = S_WAIT_IDLE;
        endcase
      end

      if (abort) begin
        state_d = S_WAIT_IDLE;
        idle_d  = 4'd0;
        busy_d  = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_WAIT_IDLE; run_q  <= '0;    last_q  <= 1'b0;  idle_q <= 4'd0;
      cnt_q    <= 7'd0;        crc_q  <= 15'd0; crc_rx_q <= 15'd0;
      id_q     <= 29'd0;       ide_q  <= 1'b0;  rtr_q   <= 1'b0;  dlc_q  <= 4'd0;
      nbytes_q <= 4'd0;        byte_q <= 8'd0;  data_q  <= '0;
      valid_q  <= 1'b0;        estf_q <= 1'b0;  ecrc_q  <= 1'b0;  efrm_q <= 1'b0;
      busy_q   <= 1'b0;
      o_id_q   <= 29'd0;       o_ide_q <= 1'b0; o_rtr_q <= 1'b0;
      o_dlc_q  <= 4'd0;        o_data_q <= '0;
    end else begin
      state_q  <= state_d;     run_q  <= run_d;  last_q  <= last_d; idle_q <= idle_d;
      cnt_q    <= cnt_d;       crc_q  <= crc_d;  crc_rx_q <= crc_rx_d;
      id_q     <= id_d;        ide_q  <= ide_d;  rtr_q   <= rtr_d;  dlc_q  <= dlc_d;
      nbytes_q <= nbytes_d;    byte_q <= byte_d; data_q  <= data_d;
      valid_q  <= valid_d;     estf_q <= estf_d; ecrc_q  <= ecrc_d; efrm_q <= efrm_d;
      busy_q   <= busy_d;
      o_id_q   <= o_id_d;      o_ide_q <= o_ide_d; o_rtr_q <= o_rtr_d;
      o_dlc_q  <= o_dlc_d;     o_data_q <= o_data_d;
    end
  end

  assign bus.frame_valid = valid_q;
  assign bus.frame_id    = o_id_q;
  assign bus.frame_ide   = o_ide_q;
  assign bus.frame_rtr   = o_rtr_q;
  assign bus.frame_dlc   = o_dlc_q;
  assign bus.frame_data  = o_data_q;
  assign bus.err_stuff   = estf_q;
  assign bus.err_crc     = ecrc_q;
  assign bus.err_form    = efrm_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: frames are built as bit streams (CRC and
// stuffing added here), fed through bit_en, and decoded fields compared with
// hand-written constants.
module tb_can_frame_rx;
  localparam int MB = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  can_frame_rx_if #(.MAX_BYTES(MB)) bus ();

  can_frame_rx #(
    .CONSEC(5), .MAX_BYTES(MB), .EXT_EN(1'b1), .CRC_POLY(15'h4599)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int gap   = 0;
  int c_val = 0, c_stf = 0, c_frm = 0, c_crc = 0;
  int v0, s0, f0, k0;
  bit tx[$];

  // Pulse counters; a pulse wider than one cycle counts more than once.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bus.frame_valid) c_val++;
      if (bus.err_stuff)   c_stf++;
      if (bus.err_form)    c_frm++;
      if (bus.err_crc)     c_crc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic snap();
    v0 = c_val; s0 = c_stf; f0 = c_frm; k0 = c_crc;
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk_i);
    bus.rx_bit = b;
    bus.bit_en = 1'b1;
    @(negedge clk_i);
    bus.bit_en = 1'b0;
    bus.rx_bit = 1'b1;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_tx(input int nbits);
    int lim;
    lim = (nbits < 0) ? tx.size() : nbits;
    for (int i = 0; i < lim; i++) send_bit(tx[i]);
    repeat (3) @(negedge clk_i);
  endtask

  // Build a full frame (SOF..EOF) into tx; flip >= 0 inverts that unstuffed bit after the CRC is computed.
  task automatic build_frame(input logic [28:0] id, input bit ide, input bit rtr,
                             input logic [3:0] dlc, input logic [63:0] data, input int flip);
    bit raw[$];
    logic [14:0] crc;
    int n, run;
    bit last, b, nx;
    tx.delete();
    raw.push_back(1'b0);
    if (!ide) begin
      for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) raw.push_back(id[i]);
      raw.push_back(1'b1); raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(id[i]);
      raw.push_back(rtr); raw.push_back(1'b0); raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--) raw.push_back(data[8*k+i]);
    crc = 15'd0;
    for (int j = 0; j < raw.size(); j++) begin
      nx  = raw[j] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nx) crc = crc ^ 15'h4599;
    end
    if (flip >= 0) raw[flip] = ~raw[flip];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    run = 0; last = 1'b0;
    for (int j = 0; j < raw.size(); j++) begin
      b = raw[j];
      tx.push_back(b);
      if (j == 0 || b != last) begin last = b; run = 1; end
      else run++;
      if (run == 5) begin tx.push_back(~b); last = ~b; run = 1; end
    end
    tx.push_back(1'b1); tx.push_back(1'b0); tx.push_back(1'b1);
    for (int i = 0; i < 7; i++) tx.push_back(1'b1);
  endtask

  task automatic test_reset();
    bus.bit_en = 1'b0; bus.rx_bit = 1'b1;
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({bus.frame_id, bus.frame_ide, bus.frame_rtr, bus.frame_dlc, bus.frame_data} !== '0) begin
      n_err++; $display("FAIL reset_frame: got id=%h dlc=%h data=%h want all zero", bus.frame_id, bus.frame_dlc, bus.frame_data);
    end
    n_vec++;
    if ({bus.frame_valid, bus.err_stuff, bus.err_crc, bus.err_form, bus.busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {bus.frame_valid, bus.err_stuff, bus.err_crc, bus.err_form, bus.busy});
    end
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_std_frame();
    gap = 0;
    send_idle(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'h5AA5, -1);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL std_pulses: got v%0d s%0d f%0d c%0d want v1 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++; if (bus.frame_id !== 29'h123) begin n_err++; $display("FAIL std_id: got %h want 123", bus.frame_id); end
    n_vec++; if ({bus.frame_ide, bus.frame_rtr} !== 2'b00) begin n_err++; $display("FAIL std_ide_rtr: got %b want 00", {bus.frame_ide, bus.frame_rtr}); end
    n_vec++; if (bus.frame_dlc !== 4'd2) begin n_err++; $display("FAIL std_dlc: got %0d want 2", bus.frame_dlc); end
    n_vec++; if (bus.frame_data !== 32'h0000_5AA5) begin n_err++; $display("FAIL std_data: got %h want 00005aa5", bus.frame_data); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL std_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_ext_rtr();
    gap = 2;
    send_idle(11);
    build_frame(29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'hDEADBEEF, -1);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL ext_pulses: got v%0d s%0d f%0d c%0d want v1 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++; if (bus.frame_id !== 29'h1ABCDEF0) begin n_err++; $display("FAIL ext_id: got %h want 1abcdef0", bus.frame_id); end
    n_vec++; if ({bus.frame_ide, bus.frame_rtr} !== 2'b11) begin n_err++; $display("FAIL ext_ide_rtr: got %b want 11", {bus.frame_ide, bus.frame_rtr}); end
    n_vec++; if (bus.frame_dlc !== 4'd4) begin n_err++; $display("FAIL ext_dlc: got %0d want 4", bus.frame_dlc); end
    n_vec++; if (bus.frame_data !== 32'h0) begin n_err++; $display("FAIL ext_data: got %h want 0", bus.frame_data); end
    gap = 0;
  endtask

  task automatic test_stuff_err();
    bit viol[8];
    viol = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    send_idle(11);
    snap();
    for (int i = 0; i < 8; i++) send_bit(viol[i]);
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL stuff_pulses: got v%0d s%0d f%0d c%0d want v0 s1 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stuff_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.frame_id !== 29'h1ABCDEF0) begin n_err++; $display("FAIL stuff_hold_id: got %h want 1abcdef0", bus.frame_id); end
    // Too little idle: the whole frame must be ignored.
    send_idle(5);
    build_frame(29'h2AB, 1'b0, 1'b0, 4'd1, 64'h3C, -1);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL stuff_short_idle: got v%0d s%0d f%0d c%0d want v0 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    send_idle(11);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL stuff_recover: got v%0d s%0d f%0d c%0d want v1 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++;
    if ({bus.frame_id, bus.frame_dlc, bus.frame_data} !== {29'h2AB, 4'd1, 32'h3C}) begin
      n_err++; $display("FAIL stuff_recover_fields: got id=%h dlc=%0d data=%h want id=2ab dlc=1 data=3c", bus.frame_id, bus.frame_dlc, bus.frame_data);
    end
  endtask

  task automatic test_crc_err();
    send_idle(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'h5AA5, 20);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
      n_err++; $display("FAIL crc_pulses: got v%0d s%0d f%0d c%0d want v0 s0 f0 c1", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++;
    if ({bus.frame_id, bus.frame_dlc, bus.frame_data} !== {29'h2AB, 4'd1, 32'h3C}) begin
      n_err++; $display("FAIL crc_hold: got id=%h dlc=%0d data=%h want id=2ab dlc=1 data=3c", bus.frame_id, bus.frame_dlc, bus.frame_data);
    end
    // Bad delimiter together with a bad CRC reports only the form error.
    send_idle(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'h5AA5, 20);
    tx[tx.size()-10] = 1'b0;
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
      n_err++; $display("FAIL form_over_crc: got v%0d s%0d f%0d c%0d want v0 s0 f1 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
  endtask

  task automatic test_eof7();
    send_idle(11);
    build_frame(29'h0F0, 1'b0, 1'b0, 4'd0, 64'h0, -1);
    tx[tx.size()-1] = 1'b0;
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL eof7_pulses: got v%0d s%0d f%0d c%0d want v1 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++;
    if ({bus.frame_id, bus.frame_dlc, bus.frame_data} !== {29'h0F0, 4'd0, 32'h0}) begin
      n_err++; $display("FAIL eof7_fields: got id=%h dlc=%0d data=%h want id=0f0 dlc=0 data=0", bus.frame_id, bus.frame_dlc, bus.frame_data);
    end
  endtask

  task automatic test_dlc15();
    send_idle(11);
    build_frame(29'h555, 1'b0, 1'b0, 4'd15, 64'h8877665544332211, -1);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL dlc15_pulses: got v%0d s%0d f%0d c%0d want v1 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    n_vec++; if (bus.frame_dlc !== 4'd15) begin n_err++; $display("FAIL dlc15_dlc: got %0d want 15", bus.frame_dlc); end
    n_vec++; if (bus.frame_data !== 32'h44332211) begin n_err++; $display("FAIL dlc15_data: got %h want 44332211", bus.frame_data); end
    n_vec++; if (bus.frame_id !== 29'h555) begin n_err++; $display("FAIL dlc15_id: got %h want 555", bus.frame_id); end
  endtask

  task automatic test_rst_mid();
    send_idle(11);
    build_frame(29'h123, 1'b0, 1'b0, 4'd2, 64'h5AA5, -1);
    send_tx(26);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", bus.busy); end
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if ({bus.frame_id, bus.frame_ide, bus.frame_rtr, bus.frame_dlc, bus.frame_data,
         bus.frame_valid, bus.err_stuff, bus.err_crc, bus.err_form, bus.busy} !== '0) begin
      n_err++; $display("FAIL rstmid_outputs: got id=%h dlc=%0d data=%h busy=%b want all zero", bus.frame_id, bus.frame_dlc, bus.frame_data, bus.busy);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    send_idle(5);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
      n_err++; $display("FAIL rstmid_ignored: got v%0d s%0d f%0d c%0d want v0 s0 f0 c0", c_val-v0, c_stf-s0, c_frm-f0, c_crc-k0);
    end
    send_idle(11);
    snap();
    send_tx(-1);
    n_vec++;
    if ({c_val-v0, bus.frame_id, bus.frame_data} !== {32'd1, 29'h123, 32'h5AA5}) begin
      n_err++; $display("FAIL rstmid_recover: got v%0d id=%h data=%h want v1 id=123 data=5aa5", c_val-v0, bus.frame_id, bus.frame_data);
    end
  endtask

  initial begin
    test_reset();
    test_std_frame();
    test_ext_rtr();
    test_stuff_err();
    test_crc_err();
    test_eof7();
    test_dlc15();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
